irq_ctrl: RTL and testbench
===========================

// Module: irq_ctrl
//
// PURPOSE
//   Interrupt collector downstream of minipit timer instances.
//   - Edge-detects per-source interrupt pulses and latches them as pending bits.
//   - Applies a per-source enable mask and picks the lowest-index pending source.
//   - Presents one registered irq/irq_id pair to the consumer and holds it until
//     an acknowledge with the matching id.
//   - Guarantees at least one low cycle on irq between successive interrupts.
//
// PARAMETERS
//   NUM_SRC  4  number of interrupt sources, legal range 1..16
//   ID_W     2  width of id ports; must equal max(1, $clog2(NUM_SRC))
//   CNT_W    8  width of the saturating overrun counter
//
// PORTS
//   clk        in   1        system clock, all logic rising-edge
//   rst_n      in   1        asynchronous active-low reset
//   enable     in   1        1 = new source edges may set pending bits
//   src_irq    in   NUM_SRC  source interrupt levels/pulses (e.g. minipit interrupting)
//   mask       in   NUM_SRC  1 = source may raise irq; 0 = held pending, not signalled
//   ack_valid  in   1        one-cycle acknowledge strobe
//   ack_id     in   ID_W     id being acknowledged
//   irq        out  1        registered interrupt request to consumer
//   irq_id     out  ID_W     id of the active request; stable while irq=1
//   pending    out  NUM_SRC  raw pending bits, masking not applied
//   ack_err    out  1        one-cycle pulse: ack outside ASSERT, or id mismatch
//   overrun    out  NUM_SRC  sticky per-source overrun flags (optional feature)
//   ovr_count  out  CNT_W    saturating total overrun count (optional feature)
//   ovr_clr    in   1        clears overrun and ovr_count (optional feature)
//
// BEHAVIOUR
//   Reset (async, rst_n=0)
//   - All outputs, src_q, pending and FSM state go to 0 immediately.
//   - FSM resets to IDLE.
//
//   Edge detection and pending bits
//   - Rising edge of source i: rise[i] = src_irq[i] & ~src_q[i], where src_q
//     is src_irq registered every cycle regardless of enable.
//   - pending[i] sets on rise[i] when enable=1.
//   - pending[i] clears on an accepted ack for id i.
//   - rise and clear on the same bit in the same cycle: set wins, so pending
//     stays 1 as a new event; this is not an overrun.
//
//   Selection
//   - cand = pending & mask; sel = lowest set index of cand.
//
//   FSM
//   - IDLE: if cand!=0 then irq_id<=sel and go to ASSERT.
//     Latency: src_irq sampled high at edge N gives pending at N, irq=1 after edge N+1.
//   - ASSERT: irq=1 and irq_id frozen. Higher-priority arrivals do not preempt.
//     - ack_valid & ack_id==irq_id: clear pending[irq_id] and go to HOLDOFF.
//     - mask[irq_id]=0, with no accepted ack: withdraw to IDLE; pending kept.
//     - Accepted ack takes precedence over a withdrawal in the same cycle.
//   - HOLDOFF: irq=0 for exactly 1 cycle, then IDLE. A new request re-raises irq
//     no earlier than 2 cycles after the ack edge.
//   - irq = (state==ASSERT), taken from a registered state; no combinational path
//     from any input to irq.
//   - irq_id keeps its last value outside ASSERT.
//
//   ack_err
//   - Pulses on ack_valid in IDLE or HOLDOFF, or on ack_id!=irq_id in ASSERT.
//   - pending and state are unchanged by an erroring ack.
//
//   enable=0
//   - Pending bits are frozen apart from ack clears; FSM and acks keep operating.
//
// CONFIGURATION
//   IRQ_CTRL_OVERRUN_EN defined
//   - An overrun on source i is rise[i] & enable & pending[i], with no same-cycle
//     clear of bit i.
//   - On an overrun: overrun[i]<=1 (sticky) and ovr_count increments, saturating
//     at all-ones.
//   - ovr_clr=1 zeroes both; an overrun in the same cycle as ovr_clr wins and
//     leaves count=1 with that flag set.
//   IRQ_CTRL_OVERRUN_EN undefined
//   - overrun and ovr_count are tied to 0, ovr_clr is ignored, and no overrun
//     logic is synthesised.
//
// TESTING
//   1 Raise src 2 for 1 cycle at edge 5 -> pending=4'b0100 after edge 5;
//     irq=1, irq_id=2 after edge 6.
//   2 In ASSERT id2, ack_valid with ack_id=2 -> irq=0 next cycle, stays 0 for the
//     HOLDOFF cycle, pending=0.
//   3 Pulse src 1 and src 3 together -> irq_id=1; ack 1 -> irq low for 1 cycle,
//     then irq_id=3 two cycles after the ack edge.
//   4 ack_id=0 while irq_id=3 -> ack_err pulse of 1 cycle; irq stays 1, pending
//     unchanged. ack while IDLE -> ack_err.
//   5 mask=4'b0000, pulse src 0 -> pending[0]=1, irq=0; set mask[0] -> irq=1,
//     irq_id=0 two cycles later. Assert rst_n=0 mid-ASSERT -> irq, pending and
//     irq_id are 0 without a clock edge.
//   6 With IRQ_CTRL_OVERRUN_EN, pulse src 0 twice without ack -> overrun=4'b0001,
//     ovr_count=1; 300 overruns -> ovr_count=255; ovr_clr -> 0. Without the
//     macro -> both remain 0.

Source files
------------

// File: rtl/irq_ctrl.sv
// ----------------------------------------------------------------------------
// irq_ctrl -- interrupt collector for a bank of timer sources.
//
// Purpose
//   Detects rising edges on each source and latches them as pending bits.
//   Selects the lowest-index pending source whose mask bit is set.
//   Presents one registered irq/irq_id pair to the consumer.
//   Holds that pair until the consumer acknowledges the matching id.
//   After an accepted ack, irq stays low for at least one cycle before the
//   next request is raised.
//
// Ports
//   clk        in   1        system clock, rising edge
//   rst_n      in   1        asynchronous active-low reset
//   enable     in   1        1 = new source edges may set pending bits
//   src_irq    in   NUM_SRC  source interrupt levels/pulses
//   mask       in   NUM_SRC  1 = source may raise irq
//   ack_valid  in   1        one-cycle acknowledge strobe
//   ack_id     in   ID_W     id being acknowledged
//   irq        out  1        registered interrupt request
//   irq_id     out  ID_W     id of the active request (held outside ASSERT)
//   pending    out  NUM_SRC  raw pending bits
//   ack_err    out  1        one-cycle pulse on an ack that was not accepted
//   overrun    out  NUM_SRC  sticky per-source overrun flags
//   ovr_count  out  CNT_W    saturating total overrun count
//   ovr_clr    in   1        clears overrun and ovr_count
//
// Configuration
//   IRQ_CTRL_OVERRUN_EN  when defined, builds the overrun flags and counter.
//                        When undefined, overrun/ovr_count are tied to 0 and
//                        ovr_clr is ignored.
// ----------------------------------------------------------------------------
module irq_ctrl #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic [NUM_SRC-1:0] mask,
  input  logic               ack_valid,
  input  logic [ID_W-1:0]    ack_id,
  output logic               irq,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_SRC-1:0] pending,
  output logic               ack_err,
  output logic [NUM_SRC-1:0] overrun,
  output logic [CNT_W-1:0]   ovr_count,
  input  logic               ovr_clr
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] cur_onehot;
  logic [NUM_SRC-1:0] clr;
  logic [NUM_SRC-1:0] cand;
  logic [ID_W-1:0]    sel;
  logic [ID_W-1:0]    irq_id_q, irq_id_d;
  logic               irq_q, irq_d;
  logic               ack_err_q, ack_err_d;
  logic               ack_accept;
  logic               cur_en;

  // An ack is only accepted while a request is outstanding and ids match.
  assign ack_accept = (state_q == ST_ASSERT) && ack_valid && (ack_id == irq_id_q);

  // Per-source edge detect, current-id decode and pending update. A new rise
  // beats a same-cycle ack clear so the fresh event is not lost.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign rise[gi]       = src_irq[gi] & ~src_q[gi];
    assign cur_onehot[gi] = (irq_id_q == ID_W'(gi));
    assign clr[gi]        = ack_accept & cur_onehot[gi];
    assign pending_d[gi]  = (rise[gi] & enable) | (pending_q[gi] & ~clr[gi]);
  end

  assign cand   = pending_q & mask;
  assign cur_en = |(cur_onehot & mask);

  // Lowest set index wins: scan from the top so the last hit is the lowest.
  always_comb begin
    sel = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand[i]) sel = ID_W'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    irq_id_d  = irq_id_q;
    ack_err_d = ack_valid && !ack_accept;
    case (state_q)
      ST_IDLE: begin
        if (|cand) begin
          state_d  = ST_ASSERT;
          irq_id_d = sel;
        end
      end
      ST_ASSERT: begin
        // Accepted ack has priority over a mask-driven withdrawal.
        if (ack_accept) begin
          state_d = ST_HOLDOFF;
        end else if (!cur_en) begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLDOFF: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    // irq is the registered copy of the next state, so no input reaches it
    // combinationally.
    irq_d = (state_d == ST_ASSERT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      src_q     <= '0;
      pending_q <= '0;
      irq_id_q  <= '0;
      irq_q     <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_irq;
      pending_q <= pending_d;
      irq_id_q  <= irq_id_d;
      irq_q     <= irq_d;
      ack_err_q <= ack_err_d;
    end
  end

  assign irq     = irq_q;
  assign irq_id  = irq_id_q;
  assign pending = pending_q;
  assign ack_err = ack_err_q;

`ifdef IRQ_CTRL_OVERRUN_EN
  // An overrun is a new edge on a source that is already pending and not
  // being cleared this cycle.
  logic [NUM_SRC-1:0] ovr_ev;
  logic [NUM_SRC-1:0] overrun_q, overrun_d;
  logic [CNT_W-1:0]   ovr_count_q, ovr_count_d;
  logic [CNT_W+4:0]   ovr_sum;

  assign ovr_ev = rise & {NUM_SRC{enable}} & pending_q & ~clr;

  // Clear is applied first so events in the clearing cycle still count.
  always_comb begin
    ovr_sum = ovr_clr ? '0 : (CNT_W+5)'(ovr_count_q);
    for (int i = 0; i < NUM_SRC; i++) begin
      ovr_sum = ovr_sum + (CNT_W+5)'(ovr_ev[i]);
    end
    if (ovr_sum > (CNT_W+5)'({CNT_W{1'b1}})) begin
      ovr_count_d = '1;
    end else begin
      ovr_count_d = ovr_sum[CNT_W-1:0];
    end
    overrun_d = (ovr_clr ? '0 : overrun_q) | ovr_ev;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q   <= '0;
      ovr_count_q <= '0;
    end else begin
      overrun_q   <= overrun_d;
      ovr_count_q <= ovr_count_d;
    end
  end

  assign overrun   = overrun_q;
  assign ovr_count = ovr_count_q;
`else
  logic unused_ovr_clr;
  assign unused_ovr_clr = ovr_clr;
  assign overrun        = '0;
  assign ovr_count      = '0;
`endif

endmodule

// File: tb/tb_irq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_irq_ctrl -- self-checking bench for irq_ctrl.
// Directed steps followed by a randomized phase, each cycle compared against
// a behavioural model of the collector kept in this file.
// ----------------------------------------------------------------------------
module tb_irq_ctrl;
  localparam int N     = 4;
  localparam int IDW   = 2;
  localparam int CW    = 8;
  localparam int CMAX  = 255;
`ifdef IRQ_CTRL_OVERRUN_EN
  localparam bit OVR = 1'b1;
`else
  localparam bit OVR = 1'b0;
`endif

  logic           clk;
  logic           rst_n;
  logic           enable;
  logic [N-1:0]   src_irq;
  logic [N-1:0]   mask;
  logic           ack_valid;
  logic [IDW-1:0] ack_id;
  logic           irq;
  logic [IDW-1:0] irq_id;
  logic [N-1:0]   pending;
  logic           ack_err;
  logic [N-1:0]   overrun;
  logic [CW-1:0]  ovr_count;
  logic           ovr_clr;

  irq_ctrl #(.NUM_SRC(N), .ID_W(IDW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .src_irq(src_irq),
    .mask(mask), .ack_valid(ack_valid), .ack_id(ack_id), .irq(irq),
    .irq_id(irq_id), .pending(pending), .ack_err(ack_err),
    .overrun(overrun), .ovr_count(ovr_count), .ovr_clr(ovr_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: a request is either outstanding (busy) or not, with a
  // one-cycle quiet gap after each accepted ack.
  bit [N-1:0] m_prev, m_pend, m_ovr;
  bit         m_busy, m_gap, m_ackerr;
  int         m_id, m_cnt;

  task automatic model_reset();
    m_prev = '0; m_pend = '0; m_ovr = '0;
    m_busy = 0; m_gap = 0; m_ackerr = 0; m_id = 0; m_cnt = 0;
  endtask

  task automatic model_update();
    bit accept, nbusy, ngap, r, c;
    int nid;
    accept = m_busy && ack_valid && (int'(ack_id) == m_id);
    nbusy = m_busy; ngap = 0; nid = m_id;
    if (m_busy) begin
      if (accept) begin nbusy = 0; ngap = 1; end
      else if (!mask[m_id]) nbusy = 0;
    end else if (!m_gap) begin
      for (int i = 0; i < N; i++) begin
        if (m_pend[i] && mask[i]) begin nbusy = 1; nid = i; break; end
      end
    end
    m_ackerr = ack_valid && !accept;
    if (OVR && ovr_clr) begin m_ovr = '0; m_cnt = 0; end
    for (int i = 0; i < N; i++) begin
      r = src_irq[i] && !m_prev[i];
      c = accept && (i == m_id);
      if (OVR && r && enable && m_pend[i] && !c) begin
        m_ovr[i] = 1;
        if (m_cnt < CMAX) m_cnt++;
      end
      if (r && enable) m_pend[i] = 1;
      else if (c)      m_pend[i] = 0;
    end
    m_prev = src_irq;
    m_busy = nbusy; m_gap = ngap; m_id = nid;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".irq"},       32'(irq),       32'(m_busy));
    check({tag, ".irq_id"},    32'(irq_id),    32'(m_id));
    check({tag, ".pending"},   32'(pending),   32'(m_pend));
    check({tag, ".ack_err"},   32'(ack_err),   32'(m_ackerr));
    check({tag, ".overrun"},   32'(overrun),   32'(m_ovr));
    check({tag, ".ovr_count"}, 32'(ovr_count), 32'(m_cnt));
  endtask

  // One clock: inputs are already set; model advances at the edge and the
  // DUT is sampled 1 time unit later.
  task automatic step(input string tag);
    @(posedge clk);
    model_update();
    #1;
    compare_all(tag);
    $display("step %-8s src=%b mask=%b en=%b ack=%b/%0d clr=%b -> irq=%b id=%0d pend=%b err=%b ovr=%b cnt=%0d",
             tag, src_irq, mask, enable, ack_valid, ack_id, ovr_clr,
             irq, irq_id, pending, ack_err, overrun, ovr_count);
  endtask

  initial begin
    rst_n = 0; enable = 0; src_irq = '0; mask = '0;
    ack_valid = 0; ack_id = '0; ovr_clr = 0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    compare_all("reset");
    rst_n = 1;

    // 1: single pulse on source 2
    mask = 4'hF; enable = 1;
    src_irq = 4'b0100; step("t1a");
    check("t1.pending", 32'(pending), 32'h4);
    check("t1.irq_low", 32'(irq), 32'h0);
    src_irq = '0; step("t1b");
    check("t1.irq", 32'(irq), 32'h1);
    check("t1.irq_id", 32'(irq_id), 32'h2);

    // 2: matching ack, then the holdoff cycle
    ack_valid = 1; ack_id = 2; step("t2a");
    ack_valid = 0;
    check("t2.irq", 32'(irq), 32'h0);
    check("t2.pending", 32'(pending), 32'h0);
    step("t2b");
    check("t2.holdoff", 32'(irq), 32'h0);

    // 3: two sources together, lowest first, next one two cycles after ack
    src_irq = 4'b1010; step("t3a");
    src_irq = '0;      step("t3b");
    check("t3.id1", 32'(irq_id), 32'h1);
    ack_valid = 1; ack_id = 1; step("t3c");
    ack_valid = 0; step("t3d");
    check("t3.gap", 32'(irq), 32'h0);
    step("t3e");
    check("t3.irq", 32'(irq), 32'h1);
    check("t3.id3", 32'(irq_id), 32'h3);

    // 4: mismatched ack, ack in holdoff, ack in idle
    ack_valid = 1; ack_id = 0; step("t4a");
    check("t4.err", 32'(ack_err), 32'h1);
    check("t4.irq", 32'(irq), 32'h1);
    check("t4.pend", 32'(pending), 32'h8);
    ack_valid = 0; step("t4b");
    check("t4.err_pulse", 32'(ack_err), 32'h0);
    ack_valid = 1; ack_id = 3; step("t4c");
    step("t4d");
    ack_valid = 0; step("t4e");
    ack_valid = 1; ack_id = 2; step("t4f");
    check("t4.idle_err", 32'(ack_err), 32'h1);
    ack_valid = 0; step("t4g");

    // 5: masked pending, unmask, then asynchronous reset mid-ASSERT
    mask = 4'h0;
    src_irq = 4'b0001; step("t5a");
    src_irq = '0; step("t5b");
    check("t5.pend", 32'(pending), 32'h1);
    check("t5.masked", 32'(irq), 32'h0);
    mask = 4'h1; step("t5c");
    step("t5d");
    check("t5.irq", 32'(irq), 32'h1);
    check("t5.id0", 32'(irq_id), 32'h0);
    src_irq = 4'b0100; step("t5e");
    src_irq = '0; step("t5f");
    #2 rst_n = 0;
    #1;
    check("t5.rst_irq", 32'(irq), 32'h0);
    check("t5.rst_pend", 32'(pending), 32'h0);
    check("t5.rst_id", 32'(irq_id), 32'h0);
    model_reset();
    @(posedge clk); #1 rst_n = 1;

    // 6: overruns on source 0 while it stays masked
    mask = 4'h0; enable = 1;
    for (int k = 0; k < 302; k++) begin
      src_irq = 4'b0001; step("t6p");
      src_irq = '0;      step("t6z");
      if (k == 1) begin
        check("t6.flag1", 32'(overrun), OVR ? 32'h1 : 32'h0);
        check("t6.cnt1", 32'(ovr_count), OVR ? 32'h1 : 32'h0);
      end
    end
    check("t6.sat", 32'(ovr_count), OVR ? 32'd255 : 32'd0);
    ovr_clr = 1; step("t6c");
    ovr_clr = 0;
    check("t6.clr", 32'(ovr_count), 32'h0);
    ovr_clr = 1; src_irq = 4'b0001; step("t6d");
    ovr_clr = 0; src_irq = '0;
    check("t6.clr_win", 32'(ovr_count), OVR ? 32'h1 : 32'h0);
    check("t6.clr_flag", 32'(overrun), OVR ? 32'h1 : 32'h0);
    step("t6e");

    // Randomized phase
    for (int k = 0; k < 600; k++) begin
      src_irq   = N'($urandom);
      mask      = ($urandom_range(0, 3) == 0) ? N'($urandom) : 4'hF;
      enable    = ($urandom_range(0, 7) != 0);
      ack_valid = ($urandom_range(0, 2) == 0);
      ack_id    = ($urandom_range(0, 3) != 0) ? IDW'(m_id) : IDW'($urandom);
      ovr_clr   = ($urandom_range(0, 31) == 0);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
